// File: rtl/sprite_palette_engine.sv
// Multi-palette sprite colour lookup with colour-key transparency, a one-cycle
// registered output and a frame-counted hit-flash overlay.
module sprite_palette_engine #(
  parameter int INDEX_W      = 4,
  parameter int COLOR_W      = 4,
  parameter int NUM_PAL      = 4,
  parameter int KEY_INDEX    = 0,
  parameter int FLASH_FRAMES = 8,
  localparam int PAL_W       = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 pix_valid,
  input  logic [INDEX_W-1:0]   index,
  input  logic [PAL_W-1:0]     pal_sel,
  input  logic                 wr_en,
  input  logic [PAL_W-1:0]     wr_pal,
  input  logic [INDEX_W-1:0]   wr_index,
  input  logic [3*COLOR_W-1:0] wr_data,
  input  logic                 frame_start,
  input  logic                 flash_trig,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue,
  output logic                 transparent,
  output logic                 out_valid,
  output logic                 flashing
);

  localparam int DEPTH   = 2 ** INDEX_W;
  localparam int ENTRY_W = 3 * COLOR_W;
  localparam int CNT_W   = $clog2(FLASH_FRAMES + 1);
  localparam logic [INDEX_W-1:0] KEY       = INDEX_W'(KEY_INDEX);
  localparam logic [CNT_W-1:0]   FLASH_CNT = CNT_W'(FLASH_FRAMES);

  typedef enum logic {IDLE, FLASH} flash_state_t;

  flash_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [ENTRY_W-1:0] pal_mem [NUM_PAL][DEPTH];
  logic [PAL_W-1:0]   rd_pal_p0;
  logic [ENTRY_W-1:0] entry_p0;
  logic               key_p0;
  logic               white_p0;

  function automatic logic [ENTRY_W-1:0] gray_entry(input int i);
    logic [31:0]        v;
    logic [COLOR_W-1:0] ch;
    v  = i;
    ch = v[COLOR_W-1:0];
    return {ch, ch, ch};
  endfunction

  // Palette storage: reset reloads the grayscale ramp; out-of-range writes drop.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int p = 0; p < NUM_PAL; p++)
        for (int i = 0; i < DEPTH; i++)
          pal_mem[p][i] <= gray_entry(i);
    end else if (wr_en && (int'(wr_pal) < NUM_PAL)) begin
      pal_mem[wr_pal][wr_index] <= wr_data;
    end
  end

  // Stage p0: lookup reads the pre-edge array, so a colliding write is seen next cycle.
  always_comb begin
    rd_pal_p0 = (int'(pal_sel) < NUM_PAL) ? pal_sel : '0;
    entry_p0  = pal_mem[rd_pal_p0][index];
    key_p0    = (index == KEY);
    white_p0  = (state_q == FLASH) && !cnt_q[0];
  end

  // Stage p1: registered colour outputs, held while no pixel is presented.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      transparent <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      out_valid <= pix_valid;
      if (pix_valid) begin
        transparent <= key_p0;
        if (key_p0)
          {red, green, blue} <= '0;
        else if (white_p0)
          {red, green, blue} <= '1;
        else
          {red, green, blue} <= entry_p0;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Retrigger takes priority over the frame tick that would otherwise count down.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (flash_trig) begin
          state_d = FLASH;
          cnt_d   = FLASH_CNT;
        end
      end
      FLASH: begin
        if (flash_trig) begin
          cnt_d = FLASH_CNT;
        end else if (frame_start) begin
          if (cnt_q > CNT_W'(1)) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign flashing = (state_q == FLASH);

endmodule

// File: tb/tb_sprite_palette_engine.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural palette/flash model.
module tb_sprite_palette_engine;

  localparam int NP = 3;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        pix_valid;
  logic [3:0]  index;
  logic [1:0]  pal_sel;
  logic        wr_en;
  logic [1:0]  wr_pal;
  logic [3:0]  wr_index;
  logic [11:0] wr_data;
  logic        frame_start;
  logic        flash_trig;
  logic [3:0]  red, green, blue;
  logic        transparent, out_valid, flashing;

  int checks = 0;
  int errors = 0;

  sprite_palette_engine #(
    .INDEX_W(4), .COLOR_W(4), .NUM_PAL(NP), .KEY_INDEX(0), .FLASH_FRAMES(8)
  ) dut (
    .Clk(Clk), .Reset(Reset), .pix_valid(pix_valid), .index(index),
    .pal_sel(pal_sel), .wr_en(wr_en), .wr_pal(wr_pal), .wr_index(wr_index),
    .wr_data(wr_data), .frame_start(frame_start), .flash_trig(flash_trig),
    .red(red), .green(green), .blue(blue), .transparent(transparent),
    .out_valid(out_valid), .flashing(flashing)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: palettes as a plain array, flash as frames remaining.
  logic [11:0] mpal [NP][16];
  int          flash_left;
  logic [11:0] e_rgb;
  logic        e_tr, e_ov, e_fl;
  int          ps;

  initial begin
    forever begin
      @(posedge Clk or posedge Reset);
      if (Reset) begin
        for (int p = 0; p < NP; p++)
          for (int i = 0; i < 16; i++)
            mpal[p][i] = {3{4'(i)}};
        flash_left = 0;
        e_rgb = '0; e_tr = 1'b0; e_ov = 1'b0; e_fl = 1'b0;
      end else begin
        e_ov = pix_valid;
        if (pix_valid) begin
          e_tr = (index == 4'd0);
          ps   = (int'(pal_sel) < NP) ? int'(pal_sel) : 0;
          if (e_tr)
            e_rgb = 12'h000;
          else if (flash_left > 0 && flash_left % 2 == 0)
            e_rgb = 12'hFFF;
          else
            e_rgb = mpal[ps][index];
        end
        if (wr_en && int'(wr_pal) < NP)
          mpal[wr_pal][wr_index] = wr_data;
        if (flash_trig)
          flash_left = 8;
        else if (frame_start && flash_left > 0)
          flash_left--;
        e_fl = (flash_left > 0);
      end
      #1;
      check("model_cycle", 32'({red, green, blue, transparent, out_valid, flashing}),
            32'({e_rgb, e_tr, e_ov, e_fl}));
    end
  end

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic pix(input logic [1:0] sel, input logic [3:0] idx);
    pix_valid = 1'b1; pal_sel = sel; index = idx;
    tick();
    pix_valid = 1'b0;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    pix_valid = 0; index = 0; pal_sel = 0; wr_en = 0; wr_pal = 0;
    wr_index = 0; wr_data = 0; frame_start = 0; flash_trig = 0;
    tick(); tick();
    check("reset_state", 32'({red, green, blue, transparent, out_valid, flashing}), 32'h0);
    Reset = 1'b0;

    pix(2'd0, 4'd5);
    check("gray_idx5", 32'({red, green, blue, transparent, out_valid}), 32'({12'h555, 1'b0, 1'b1}));
    pix(2'd0, 4'd0);
    check("key_idx0", 32'({red, green, blue, transparent}), 32'({12'h000, 1'b1}));

    wr_en = 1; wr_pal = 2; wr_index = 3; wr_data = 12'hA5C;
    tick();
    wr_en = 0;
    pix(2'd2, 4'd3);
    check("written_p2i3", 32'({red, green, blue}), 32'h00000A5C);
    pix(2'd1, 4'd3);
    check("other_pal_p1i3", 32'({red, green, blue}), 32'h00000333);

    wr_en = 1; wr_pal = 0; wr_index = 7; wr_data = 12'h123;
    pix(2'd0, 4'd7);
    wr_en = 0;
    check("collision_old", 32'({red, green, blue}), 32'h00000777);
    pix(2'd0, 4'd7);
    check("collision_new", 32'({red, green, blue}), 32'h00000123);

    wr_en = 1; wr_pal = 3; wr_index = 5; wr_data = 12'hFFF;
    tick();
    wr_en = 0;
    pix(2'd3, 4'd5);
    check("bad_sel_pal0", 32'({red, green, blue}), 32'h00000555);
    pix(2'd2, 4'd5);
    check("bad_write_ignored", 32'({red, green, blue}), 32'h00000555);

    flash_trig = 1;
    tick();
    flash_trig = 0;
    check("flash_start", 32'(flashing), 32'h1);
    for (int f = 0; f < 8; f++) begin
      pix(2'd0, 4'd4);
      check($sformatf("flash_frame%0d", f), 32'({red, green, blue}),
            (f % 2 == 0) ? 32'h00000FFF : 32'h00000444);
      pix(2'd1, 4'd0);
      check($sformatf("flash_key%0d", f), 32'({red, green, blue, transparent}), 32'({12'h000, 1'b1}));
      frame();
    end
    check("flash_end", 32'(flashing), 32'h0);
    frame();
    check("idle_frame", 32'(flashing), 32'h0);

    flash_trig = 1;
    tick();
    flash_trig = 0;
    for (int f = 0; f < 5; f++) frame();
    flash_trig = 1; frame_start = 1;
    tick();
    flash_trig = 0; frame_start = 0;
    pix(2'd0, 4'd4);
    check("retrig_white", 32'({red, green, blue}), 32'h00000FFF);
    for (int f = 0; f < 7; f++) frame();
    check("retrig_still", 32'(flashing), 32'h1);
    frame();
    check("retrig_end", 32'(flashing), 32'h0);

    flash_trig = 1;
    tick();
    flash_trig = 0;
    pix(2'd0, 4'd4);
    check("pre_reset_white", 32'({red, green, blue}), 32'h00000FFF);
    #1 Reset = 1'b1;
    #2;
    check("async_reset", 32'({red, green, blue, transparent, out_valid, flashing}), 32'h0);
    Reset = 1'b0;
    pix(2'd0, 4'd7);
    check("gray_restored_p0", 32'({red, green, blue}), 32'h00000777);
    pix(2'd2, 4'd3);
    check("gray_restored_p2", 32'({red, green, blue}), 32'h00000333);

    for (int n = 0; n < 3000; n++) begin
      pix_valid   = ($urandom_range(0, 3) != 0);
      index       = 4'($urandom_range(0, 15));
      pal_sel     = 2'($urandom_range(0, 3));
      wr_en       = ($urandom_range(0, 3) == 0);
      wr_pal      = 2'($urandom_range(0, 3));
      wr_index    = ($urandom_range(0, 1) == 0) ? index : 4'($urandom_range(0, 15));
      wr_data     = 12'($urandom);
      frame_start = ($urandom_range(0, 5) == 0);
      flash_trig  = ($urandom_range(0, 59) == 0);
      tick();
    end
    pix_valid = 0; wr_en = 0; frame_start = 0; flash_trig = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_palette_engine.md
Name: sprite_palette_engine

Overview:
Registered, writable multi-palette colour lookup for sprite pixels. It sits between the sprite ROM index output and the VGA colour mux. It adds four things beyond a fixed single palette: several runtime-selectable palettes (e.g. player-2 recolour), a colour-key transparency flag, a one-cycle pipelined output, and a frame-counted hit-flash effect.

Parameters:
INDEX_W, 4, bits per pixel colour index; each palette holds 2**INDEX_W entries
COLOR_W, 4, bits per colour channel; an entry is 3*COLOR_W bits, packed {r,g,b}
NUM_PAL, 4, number of palettes; must be >= 1
KEY_INDEX, 0, index value treated as transparent
FLASH_FRAMES, 8, frames a hit flash lasts; must be >= 1

Ports:
Clk  in  1  system clock, all logic on rising edge
Reset  in  1  asynchronous, active-high reset
pix_valid  in  1  index/pal_sel valid this cycle
index  in  INDEX_W  pixel colour index
pal_sel  in  max(1,clog2(NUM_PAL))  palette used for this pixel
wr_en  in  1  palette entry write strobe
wr_pal  in  max(1,clog2(NUM_PAL))  palette to write
wr_index  in  INDEX_W  entry to write
wr_data  in  3*COLOR_W  {r,g,b} value to write
frame_start  in  1  one-cycle pulse per frame (vsync edge)
flash_trig  in  1  start or restart the hit flash
red  out  COLOR_W  registered red
green  out  COLOR_W  registered green
blue  out  COLOR_W  registered blue
transparent  out  1  registered, pixel equals KEY_INDEX
out_valid  out  1  registered copy of pix_valid
flashing  out  1  flash state active

Behaviour:
- Reset (async, any time, including mid-flash or mid-write):
  - red/green/blue = 0; transparent = 0; out_valid = 0; flashing = 0; flash counter = 0; FSM = IDLE.
  - Every entry i of every palette loads a grayscale ramp: each channel = i, zero-extended or truncated to COLOR_W.
- Palette storage: NUM_PAL x 2**INDEX_W registers of 3*COLOR_W bits each.
- Write:
  - When wr_en=1 and wr_pal < NUM_PAL, entry [wr_pal][wr_index] <= wr_data at the clock edge.
  - wr_pal >= NUM_PAL: the write is ignored.
- Lookup pipeline, latency exactly 1 cycle, no stalls:
  - out_valid <= pix_valid every cycle.
  - When pix_valid=1:
    - transparent <= (index == KEY_INDEX).
    - Colour <= entry [pal_sel][index]; pal_sel >= NUM_PAL uses palette 0.
  - When pix_valid=0: red/green/blue/transparent hold their previous values.
- Read/write collision on the same entry in the same cycle: the read returns the OLD value; the new value is visible to a read in the next cycle.
- Transparent pixels always output colour 0, regardless of palette contents or flash.
- Flash FSM, states IDLE and FLASH; counter cnt is sized to hold FLASH_FRAMES.
  - IDLE: flash_trig -> FLASH, cnt <= FLASH_FRAMES.
  - FLASH, flash_trig=1: cnt <= FLASH_FRAMES (retrigger). flash_trig wins over a simultaneous frame_start.
  - FLASH, frame_start=1, flash_trig=0, cnt > 1: cnt <= cnt-1.
  - FLASH, frame_start=1, flash_trig=0, cnt == 1: -> IDLE, cnt <= 0.
  - flashing = (state == FLASH).
- Flash colour:
  - A non-transparent pixel sampled while state==FLASH and cnt[0]==0 outputs all channels = all-ones.
  - Otherwise the pixel outputs its palette colour.
  - The state used is the state at the sampling edge, before any same-cycle update.
  - With FLASH_FRAMES=8 the sequence is white, normal, white, normal ... giving 4 white frames of 8.
- frame_start while IDLE has no effect.

Test Plan:
- Reset release, pix_valid=1, pal_sel=0, index=5 -> next cycle red=green=blue=5, transparent=0, out_valid=1; index=0 -> rgb=0, transparent=1.
- Write pal 2 entry 3 = 12'hA5C, then read pal_sel=2 index=3 -> {A,5,C}; read pal_sel=1 index=3 -> {3,3,3}.
- Same-cycle write pal0 idx7 = 12'h123 and read pal0 idx7 -> 12'h777 returned; read repeated next cycle -> 12'h123.
- wr_pal=3 with NUM_PAL=3 -> write ignored; pal_sel=3 read -> palette 0 contents.
- flash_trig, then 8 frame_start pulses, index=4 sampled each frame -> rgb FFF,444,FFF,444,FFF,444,FFF,444; flashing falls after the 8th pulse; index 0 always rgb 0.
- flash_trig and frame_start together at cnt=3 -> cnt=8; assert Reset mid-flash -> flashing=0 and all outputs 0 immediately, palettes back to grayscale.
